timer_counter: RTL and testbench

Counting core of the single 8-bit timer. Consumes `TDR` and `TCR` from the register/APB control block and returns `TCNT` plus the `TMR_OVF`/`TMR_UDF` event flags that feed `TSR`. Contains an internal PCLK prescaler selected by `TCR[1:0]`, and the up/down counter with load, enable and wrap detection.

---
 rtl/timer_counter.sv | 89 ++++++++
 tb/tb_timer_counter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Counting core of the 8-bit timer: PCLK prescaler selected by TCR[1:0] plus an
// up/down counter with load, enable and sticky wrap flags.
module timer_counter (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic [7:0] TDR,
  input  logic [7:0] TCR,
  input  logic [1:0] FLAG_CLR,
  output logic [7:0] TCNT,
  output logic       TMR_OVF,
  output logic       TMR_UDF
);

  localparam int DATA_WIDTH = 8;
  localparam int DIV_WIDTH  = 4;

  logic [DATA_WIDTH-1:0] r_tcnt;
  logic [DIV_WIDTH-1:0]  r_div;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_load;
  logic                  w_dir;
  logic                  w_en;
  logic [1:0]            w_cks;
  logic [DIV_WIDTH-1:0]  w_mask;
  logic                  w_tick;
  logic                  w_wrap_up;
  logic                  w_wrap_dn;
  logic [DATA_WIDTH-1:0] w_tcnt_nxt;
  logic [DIV_WIDTH-1:0]  w_div_nxt;

  assign w_load = TCR[7];
  assign w_dir  = TCR[5];
  assign w_en   = TCR[4];
  assign w_cks  = TCR[1:0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_mask = 4'b0001;
    case (w_cks)
      2'b00:   w_mask = 4'b0001;
      2'b01:   w_mask = 4'b0011;
      2'b10:   w_mask = 4'b0111;
      default: w_mask = 4'b1111;
    endcase
  end

  // A tick needs the low CKS+1 divider bits all set; LOAD suppresses it entirely.
  assign w_tick    = !w_load && w_en && ((r_div & w_mask) == w_mask);
  assign w_wrap_up = w_tick && !w_dir && (r_tcnt == {DATA_WIDTH{1'b1}});
  assign w_wrap_dn = w_tick &&  w_dir && (r_tcnt == {DATA_WIDTH{1'b0}});

  always_comb begin
    w_tcnt_nxt = r_tcnt;
    w_div_nxt  = '0;
    if (w_load) begin
      w_tcnt_nxt = TDR;
    end else if (w_en) begin
      w_div_nxt = r_div + 1'b1;
      if (w_tick) begin
        w_tcnt_nxt = w_dir ? r_tcnt - 1'b1 : r_tcnt + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_tcnt <= '0;
      r_div  <= '0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else begin
      r_tcnt <= w_tcnt_nxt;
      r_div  <= w_div_nxt;
      // A wrap on the same edge as a clear keeps the flag set.
      if (w_wrap_up)        r_ovf <= 1'b1;
      else if (FLAG_CLR[0]) r_ovf <= 1'b0;
      if (w_wrap_dn)        r_udf <= 1'b1;
      else if (FLAG_CLR[1]) r_udf <= 1'b0;
    end
  end

  assign TCNT    = r_tcnt;
  assign TMR_OVF = r_ovf;
  assign TMR_UDF = r_udf;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized control
// traffic compared each cycle against an arithmetic reference model.
module tb_timer_counter;

  logic       PCLK;
  logic       PRESETn;
  logic [7:0] TDR;
  logic [7:0] TCR;
  logic [1:0] FLAG_CLR;
  logic [7:0] TCNT;
  logic       TMR_OVF;
  logic       TMR_UDF;

  int n_vec;
  int n_err;

  // reference model state: count as plain integer, prescale phase as cycles since restart
  int m_cnt;
  int m_phase;
  bit m_ovf;
  bit m_udf;

  timer_counter dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .TDR      (TDR),
    .TCR      (TCR),
    .FLAG_CLR (FLAG_CLR),
    .TCNT     (TCNT),
    .TMR_OVF  (TMR_OVF),
    .TMR_UDF  (TMR_UDF)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_phase = 0;
    m_ovf   = 0;
    m_udf   = 0;
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    int  period;
    bit  set_o;
    bit  set_u;
    set_o = 0;
    set_u = 0;
    if (TCR[7]) begin
      m_cnt   = int'(TDR);
      m_phase = 0;
    end else if (TCR[4]) begin
      period = 2 << TCR[1:0];
      if (((m_phase + 1) % period) == 0) begin
        if (TCR[5]) begin
          if (m_cnt == 0) begin m_cnt = 255; set_u = 1; end
          else m_cnt = m_cnt - 1;
        end else begin
          if (m_cnt == 255) begin m_cnt = 0; set_o = 1; end
          else m_cnt = m_cnt + 1;
        end
      end
      m_phase = (m_phase + 1) % 16;
    end else begin
      m_phase = 0;
    end
    m_ovf = set_o ? 1'b1 : (FLAG_CLR[0] ? 1'b0 : m_ovf);
    m_udf = set_u ? 1'b1 : (FLAG_CLR[1] ? 1'b0 : m_udf);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge PCLK);
      model_edge();
      #1;
      check("tcnt", TCNT, 8'(m_cnt));
      check("ovf", {7'd0, TMR_OVF}, {7'd0, m_ovf});
      check("udf", {7'd0, TMR_UDF}, {7'd0, m_udf});
    end
  endtask

  task automatic load(input logic [7:0] val, input logic [1:0] clr);
    TDR      = val;
    TCR      = 8'h80;
    FLAG_CLR = clr;
    run(1);
    FLAG_CLR = 2'b00;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    TDR      = 8'h00;
    TCR      = 8'h00;
    FLAG_CLR = 2'b00;
    PRESETn  = 1'b0;
    model_reset();
    #12;
    check("rst_tcnt", TCNT, 8'h00);
    check("rst_ovf", {7'd0, TMR_OVF}, 8'h00);
    check("rst_udf", {7'd0, TMR_UDF}, 8'h00);
    PRESETn = 1'b1;
    run(2);

    // up count with overflow, then clear
    load(8'hFE, 2'b11);
    TCR = 8'h10;
    run(2);
    check("up_ff", TCNT, 8'hFF);
    run(2);
    check("up_00", TCNT, 8'h00);
    check("ovf_set", {7'd0, TMR_OVF}, 8'h01);
    FLAG_CLR = 2'b01;
    run(1);
    FLAG_CLR = 2'b00;
    check("ovf_clr", {7'd0, TMR_OVF}, 8'h00);

    // down count with underflow at CKS=11
    load(8'h01, 2'b11);
    TCR = 8'h33;
    run(16);
    check("dn_00", TCNT, 8'h00);
    run(16);
    check("dn_ff", TCNT, 8'hFF);
    check("udf_set", {7'd0, TMR_UDF}, 8'h01);
    check("ovf_quiet", {7'd0, TMR_OVF}, 8'h00);

    // prescaler periods: 5 ticks take 10/20/40/80 edges
    for (int c = 0; c < 4; c++) begin
      load(8'h00, 2'b11);
      TCR = 8'h10 | 8'(c);
      run((10 << c) - 1);
      check("presc_4", TCNT, 8'h04);
      run(1);
      check("presc_5", TCNT, 8'h05);
    end

    // set-vs-clear collision on FF->00 wrap
    load(8'hFE, 2'b11);
    TCR = 8'h10;
    run(3);
    FLAG_CLR = 2'b01;
    run(1);
    check("coll_tcnt", TCNT, 8'h00);
    check("coll_ovf", {7'd0, TMR_OVF}, 8'h01);
    run(1);
    FLAG_CLR = 2'b00;
    check("coll_clr", {7'd0, TMR_OVF}, 8'h00);

    // priority and hold
    FLAG_CLR = 2'b11;
    run(1);
    FLAG_CLR = 2'b00;
    TDR = 8'h7A;
    TCR = 8'h90;
    for (int i = 0; i < 20; i++) begin
      run(1);
      check("prio_tcnt", TCNT, 8'h7A);
      check("prio_flags", {6'd0, TMR_UDF, TMR_OVF}, 8'h00);
    end
    TCR = 8'h00;
    run(5);
    check("hold", TCNT, 8'h7A);
    TCR = 8'h10;
    run(2);
    check("restart", TCNT, 8'h7B);

    // async reset mid-count, then restart from zero
    run(3);
    #3;
    PRESETn = 1'b0;
    #1;
    check("arst_tcnt", TCNT, 8'h00);
    check("arst_flags", {6'd0, TMR_UDF, TMR_OVF}, 8'h00);
    model_reset();
    #2;
    PRESETn = 1'b1;
    TCR = 8'h10;
    run(1);
    check("arst_e1", TCNT, 8'h00);
    run(1);
    check("arst_e2", TCNT, 8'h01);

    // randomized control traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) begin
        TCR = 8'($urandom);
        if ($urandom_range(5) != 0) TCR[7] = 1'b0;
      end
      if ($urandom_range(3) == 0) TDR = 8'($urandom);
      FLAG_CLR = ($urandom_range(7) == 0) ? 2'($urandom) : 2'b00;
      run(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
